// File: rtl/core_regfile_pkg.sv
// Shared definitions for the integer register file and its scoreboard.
package core_regs_pkg;

    // Address width needed to index nregs architectural registers.
    function automatic int unsigned reg_aw(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    // Register address in the default 32-entry configuration.
    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/core_regfile_if.sv
// Read/write/reserve bus between issue, writeback and the register file.
interface core_regfile_if
    import core_regs_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1
);
    localparam int unsigned AW = reg_aw(NREGS);

    logic [NREAD-1:0][AW-1:0]    raddr_i;
    logic [NREAD-1:0][XLEN-1:0]  rdata_o;
    logic [NREAD-1:0]            rbusy_o;
    logic [NWRITE-1:0]           we_i;
    logic [NWRITE-1:0][AW-1:0]   waddr_i;
    logic [NWRITE-1:0][XLEN-1:0] wdata_i;
    logic                        rsv_i;
    logic [AW-1:0]               rsv_addr_i;
    logic                        rsv_ok_o;
    logic [NREGS-1:0]            busy_o;

    // Pipeline side: drives addresses, write data and reservations.
    modport master (
        output raddr_i, we_i, waddr_i, wdata_i, rsv_i, rsv_addr_i,
        input  rdata_o, rbusy_o, rsv_ok_o, busy_o
    );

    // Register file side.
    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i, rsv_i, rsv_addr_i,
        output rdata_o, rbusy_o, rsv_ok_o, busy_o
    );

endinterface

// File: rtl/core_regfile_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, writeback releases it.
module core_scoreboard
    import core_regs_pkg::*;
#(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NWRITE = 1,
    localparam int unsigned AW    = reg_aw(NREGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NWRITE-1:0]         we_i,
    input  logic [NWRITE-1:0][AW-1:0] waddr_i,
    input  logic                      rsv_i,
    input  logic [AW-1:0]             rsv_addr_i,
    output logic                      rsv_ok_o,
    output logic [NREGS-1:0]          busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] clr_w;
    logic [NREGS-1:0] set_w;
    logic             rsv_ok_w;

    // Release vector: any write port targeting a register clears its busy bit.
    always_comb begin
        clr_w = '0;
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (we_i[j]) begin
                clr_w[waddr_i[j]] = 1'b1;
            end
        end
        clr_w[0] = 1'b0;
    end

    // Accept a reservation unless the target is busy and not being released now.
    always_comb begin
        rsv_ok_w = rsv_i & ((rsv_addr_i == '0) | ~busy_q[rsv_addr_i] | clr_w[rsv_addr_i]);
    end

    // Next busy state; a reservation wins over a same-cycle release.
    always_comb begin
        set_w = '0;
        if (rsv_ok_w && (rsv_addr_i != '0)) begin
            set_w[rsv_addr_i] = 1'b1;
        end
        busy_d    = set_w | (busy_q & ~clr_w);
        busy_d[0] = 1'b0;
    end

    // Busy register with asynchronous clear; reset drops in-flight reservations.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rsv_ok_o = rsv_ok_w;
    assign busy_o   = busy_q;

endmodule

// File: rtl/core_regfile.sv
// Integer register file: NREAD read ports, NWRITE write ports, optional
// write-to-read bypass and a busy scoreboard for RAW/WAW hazard stalls.
module core_regfile
    import core_regs_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    core_regfile_if.slave rf
);

    localparam int unsigned AW = reg_aw(NREGS);

    logic [XLEN-1:0]             regs_q [NREGS];
    logic [XLEN-1:0]             regs_d [NREGS];
    logic [NREGS-1:0]            busy_w;
    logic                        rsv_ok_w;
    logic [NREAD-1:0][XLEN-1:0]  rdata_w;
    logic [NREAD-1:0]            rbusy_w;

    core_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we_i       (rf.we_i),
        .waddr_i    (rf.waddr_i),
        .rsv_i      (rf.rsv_i),
        .rsv_addr_i (rf.rsv_addr_i),
        .rsv_ok_o   (rsv_ok_w),
        .busy_o     (busy_w)
    );

    // Write merge: ports applied in ascending order so the highest port wins; x0 dropped.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (rf.we_i[j] && (rf.waddr_i[j] != '0)) begin
                regs_d[rf.waddr_i[j]] = rf.wdata_i[j];
            end
        end
        regs_d[0] = '0;
    end

    // Data array in flops with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Read ports: stored value and busy bit, overridden by same-cycle writes when bypassing.
    always_comb begin
        rdata_w = '0;
        rbusy_w = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            rdata_w[k] = regs_q[rf.raddr_i[k]];
            rbusy_w[k] = busy_w[rf.raddr_i[k]];
            if ((BYPASS != 0) && (rf.raddr_i[k] != '0)) begin
                for (int unsigned j = 0; j < NWRITE; j++) begin
                    if (rf.we_i[j] && (rf.waddr_i[j] == rf.raddr_i[k])) begin
                        rdata_w[k] = rf.wdata_i[j];
                        rbusy_w[k] = 1'b0;
                    end
                end
            end
        end
    end

    assign rf.rdata_o  = rdata_w;
    assign rf.rbusy_o  = rbusy_w;
    assign rf.rsv_ok_o = rsv_ok_w;
    assign rf.busy_o   = busy_w;

endmodule

// File: tb/tb_core_regfile.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances (NWRITE=2) share stimulus
// and are compared every cycle against an array-based reference model.
module tb_core_regfile;
    import core_regs_pkg::*;

    logic                clk;
    logic                rst_n;
    logic [1:0][4:0]     raddr;
    logic [1:0]          we;
    logic [1:0][4:0]     waddr;
    logic [1:0][31:0]    wdata;
    logic                rsv;
    reg_addr_t           rsv_addr;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    int          errors;
    int          checks;
    bit          chk_en;

    core_regfile_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) if_b ();
    core_regfile_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) if_n ();

    assign if_b.raddr_i = raddr;    assign if_n.raddr_i = raddr;
    assign if_b.we_i = we;          assign if_n.we_i = we;
    assign if_b.waddr_i = waddr;    assign if_n.waddr_i = waddr;
    assign if_b.wdata_i = wdata;    assign if_n.wdata_i = wdata;
    assign if_b.rsv_i = rsv;        assign if_n.rsv_i = rsv;
    assign if_b.rsv_addr_i = rsv_addr; assign if_n.rsv_addr_i = rsv_addr;

    core_regfile #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_byp (
        .clk_i (clk), .rst_ni (rst_n), .rf (if_b)
    );
    core_regfile #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0)) u_nob (
        .clk_i (clk), .rst_ni (rst_n), .rf (if_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit exp_rsv_ok();
        bit released = 1'b0;
        if (!rsv) return 1'b0;
        if (rsv_addr == 0) return 1'b1;
        for (int j = 0; j < 2; j++)
            if (we[j] && waddr[j] == rsv_addr) released = 1'b1;
        return !m_busy[rsv_addr] || released;
    endfunction

    function automatic logic [31:0] exp_rdata(input int k, input bit byp);
        int a = int'(raddr[k]);
        logic [31:0] v = m_regs[a];
        if (byp && a != 0)
            for (int j = 0; j < 2; j++)
                if (we[j] && int'(waddr[j]) == a) v = wdata[j];
        return v;
    endfunction

    function automatic bit exp_rbusy(input int k, input bit byp);
        int a = int'(raddr[k]);
        bit b = m_busy[a];
        if (byp && a != 0)
            for (int j = 0; j < 2; j++)
                if (we[j] && int'(waddr[j]) == a) b = 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_clock();
        bit ok = exp_rsv_ok();
        for (int j = 0; j < 2; j++) begin
            if (we[j]) begin
                if (waddr[j] != 0) m_regs[waddr[j]] = wdata[j];
                m_busy[waddr[j]] = 1'b0;
            end
        end
        if (ok && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check32("byp rdata", if_b.rdata_o[k], exp_rdata(k, 1'b1));
                check32("nob rdata", if_n.rdata_o[k], exp_rdata(k, 1'b0));
                check32("byp rbusy", 32'(if_b.rbusy_o[k]), 32'(exp_rbusy(k, 1'b1)));
                check32("nob rbusy", 32'(if_n.rbusy_o[k]), 32'(exp_rbusy(k, 1'b0)));
            end
            check32("byp rsv_ok", 32'(if_b.rsv_ok_o), 32'(exp_rsv_ok()));
            check32("nob rsv_ok", 32'(if_n.rsv_ok_o), 32'(exp_rsv_ok()));
            check32("byp busy_o", if_b.busy_o, exp_busy());
            check32("nob busy_o", if_n.busy_o, exp_busy());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        raddr = '0; we = '0; waddr = '0; wdata = '0; rsv = 1'b0; rsv_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        chk_en = 1'b0;
        idle();
        rst_n = 1'b0;
        model_clear();
        chk_en = 1'b1;
        tick();
        tick();
        check32("reset busy_o", if_b.busy_o, 32'h0);
        rst_n = 1'b1;

        // Sweep every address on both ports after reset.
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            raddr[1] = 5'(31 - a);
            tick();
        end

        // Same-cycle write/read of x5.
        idle();
        we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF; raddr[0] = 5'd5;
        settle();
        check32("x5 bypass same cycle", if_b.rdata_o[0], 32'hDEADBEEF);
        check32("x5 no-bypass same cycle", if_n.rdata_o[0], 32'h0);
        tick();
        idle(); raddr[0] = 5'd5;
        settle();
        check32("x5 bypass next cycle", if_b.rdata_o[0], 32'hDEADBEEF);
        check32("x5 no-bypass next cycle", if_n.rdata_o[0], 32'hDEADBEEF);

        // x0 stays zero and is never reserved.
        idle(); we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'h1234; raddr[0] = 5'd0;
        settle();
        check32("x0 write bypass", if_b.rdata_o[0], 32'h0);
        tick();
        idle(); rsv = 1'b1; rsv_addr = 5'd0;
        settle();
        check32("x0 rsv_ok", 32'(if_b.rsv_ok_o), 32'h1);
        tick();
        idle(); settle();
        check32("x0 never busy", if_b.busy_o, 32'h0);

        // Reserve x7, WAW refusal, then release-and-re-reserve.
        idle(); rsv = 1'b1; rsv_addr = 5'd7;
        settle();
        check32("x7 first rsv_ok", 32'(if_n.rsv_ok_o), 32'h1);
        tick();
        idle(); rsv = 1'b1; rsv_addr = 5'd7; raddr[0] = 5'd7;
        settle();
        check32("x7 second rsv refused", 32'(if_b.rsv_ok_o), 32'h0);
        check32("x7 rbusy", 32'(if_b.rbusy_o[0]), 32'h1);
        tick();
        idle(); we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h55; rsv = 1'b1; rsv_addr = 5'd7;
        raddr[0] = 5'd7;
        settle();
        check32("x7 release+rsv ok", 32'(if_b.rsv_ok_o), 32'h1);
        check32("x7 bypass rbusy clear", 32'(if_b.rbusy_o[0]), 32'h0);
        check32("x7 no-bypass rbusy old", 32'(if_n.rbusy_o[0]), 32'h1);
        tick();
        idle(); raddr[0] = 5'd7;
        settle();
        check32("x7 still busy", 32'(if_n.busy_o[7]), 32'h1);
        check32("x7 data", if_n.rdata_o[0], 32'h55);
        we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h66;
        tick();
        idle(); settle();
        check32("x7 released", 32'(if_b.busy_o[7]), 32'h0);

        // Two write ports collide on x3: port 1 wins.
        idle(); rsv = 1'b1; rsv_addr = 5'd3;
        tick();
        idle(); we = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd3;
        wdata[0] = 32'hA; wdata[1] = 32'hB; raddr[0] = 5'd3;
        settle();
        check32("x3 collide bypass", if_b.rdata_o[0], 32'hB);
        tick();
        idle(); raddr[0] = 5'd3;
        settle();
        check32("x3 collide stored", if_n.rdata_o[0], 32'hB);
        check32("x3 busy cleared", 32'(if_n.busy_o[3]), 32'h0);

        // Randomized traffic biased toward a few registers to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++)
                raddr[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            for (int j = 0; j < 2; j++) begin
                we[j]    = ($urandom_range(0, 9) < 4);
                waddr[j] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wdata[j] = $urandom;
            end
            rsv      = $urandom_range(0, 1) == 1;
            rsv_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            tick();
        end

        // Asynchronous reset in the middle of a reservation.
        idle(); we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h99; rsv = 1'b1; rsv_addr = 5'd9;
        settle();
        check32("x9 rsv_ok", 32'(if_b.rsv_ok_o), 32'h1);
        tick();
        idle(); raddr[0] = 5'd9;
        settle();
        check32("x9 busy before reset", 32'(if_b.busy_o[9]), 32'h1);
        check32("x9 data before reset", if_b.rdata_o[0], 32'h99);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        check32("async reset busy byp", if_b.busy_o, 32'h0);
        check32("async reset busy nob", if_n.busy_o, 32'h0);
        check32("async reset x9 data", if_n.rdata_o[0], 32'h0);
        check32("async reset x9 rbusy", 32'(if_n.rbusy_o[0]), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            raddr[0] = 5'($urandom_range(0, 31));
            raddr[1] = 5'($urandom_range(0, 31));
            we       = 2'($urandom_range(0, 3));
            waddr[0] = 5'($urandom_range(0, 15));
            waddr[1] = 5'($urandom_range(0, 15));
            wdata[0] = $urandom;
            wdata[1] = $urandom;
            rsv      = $urandom_range(0, 1) == 1;
            rsv_addr = 5'($urandom_range(0, 15));
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
